// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - serial 8x8 RGB frame receiver and Wishbone row writer
module uart_frame_loader #(
   parameter int CLK_HZ         = 25_000_000,
   parameter int BAUD           = 115200,
   parameter int TIMEOUT_CYCLES = 250_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_uart_rx,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [2:0]  o_wb_addr,
   output logic [3:0]  o_wb_sel,
   output logic [31:0] o_wb_wdata,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_rdata,
   output logic        o_frame_done,
   output logic        o_err
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
   localparam int TO_CNT_W     = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [BIT_CNT_W-1:0] HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_CNT_W-1:0] FULL_LAST = BIT_CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_CNT_W-1:0]  TO_LAST   = TO_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]           SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {
      P_HUNT, P_DATA, P_CSUM, P_WLOAD, P_WSTB, P_WACK, P_WNEXT, P_WDONE
   } p_state_t;

   // read data is never consumed; this keeps the port visibly intentional
   logic unused_rdata;
   assign unused_rdata = ^i_wb_rdata;

   // ---------------------------------------------------------------- receiver
   logic                 rx_meta, rx_sync, rx_prev;
   rx_state_t            rx_state, rx_state_nxt;
   logic [BIT_CNT_W-1:0] rx_cnt;
   logic [2:0]           rx_bit_idx;
   logic [7:0]           rx_shift;
   logic                 rx_tick;
   logic                 rx_valid;
   logic                 rx_ferr;
   logic [7:0]           rx_byte;

   // two-flop synchronizer plus one delay tap for falling-edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // start bit is checked at half a bit; every later sample is a full bit apart
   assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == FULL_LAST);

   // receiver state register
   always_ff @(posedge clk) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_state_nxt;
   end

   // receiver next-state: a high line at mid-start means a glitch, not a byte
   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:  if (rx_prev && !rx_sync) rx_state_nxt = RX_START;
         RX_START: if (rx_tick) rx_state_nxt = rx_sync ? RX_IDLE : RX_BITS;
         RX_BITS:  if (rx_tick && rx_bit_idx == 3'd7) rx_state_nxt = RX_STOP;
         RX_STOP:  if (rx_tick) rx_state_nxt = RX_IDLE;
         default:  rx_state_nxt = RX_IDLE;
      endcase
   end

   // receiver datapath: bit timer, LSB-first shifter, byte / framing-error pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_cnt     <= '0;
         rx_bit_idx <= 3'd0;
         rx_shift   <= 8'd0;
         rx_valid   <= 1'b0;
         rx_ferr    <= 1'b0;
         rx_byte    <= 8'd0;
      end else begin
         rx_valid <= 1'b0;
         rx_ferr  <= 1'b0;
         if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
         else                                rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == RX_START) rx_bit_idx <= 3'd0;
         if (rx_state == RX_BITS && rx_tick) begin
            rx_shift   <= {rx_sync, rx_shift[7:1]};
            rx_bit_idx <= rx_bit_idx + 3'd1;
         end
         if (rx_state == RX_STOP && rx_tick) begin
            rx_valid <= rx_sync;
            rx_ferr  <= !rx_sync;
            rx_byte  <= rx_shift;
         end
      end
   end

   // ------------------------------------------------------ parser and writer
   p_state_t            p_state, p_state_nxt;
   logic [4:0]          byte_cnt;
   logic [7:0]          csum_acc;
   logic [TO_CNT_W-1:0] to_cnt;
   logic [2:0]          row;
   logic [31:0]         frame_buf [8];
   logic                in_frame, in_write, timeout_hit, csum_bad, last_row;

   assign in_frame    = (p_state == P_DATA) || (p_state == P_CSUM);
   assign in_write    = (p_state == P_WLOAD) || (p_state == P_WSTB) || (p_state == P_WACK) ||
                        (p_state == P_WNEXT) || (p_state == P_WDONE);
   assign timeout_hit = in_frame && !rx_valid && (to_cnt == TO_LAST);
   assign csum_bad    = (p_state == P_CSUM) && rx_valid && (rx_byte != csum_acc);
   assign last_row    = (row == 3'd7);

   // parser state register
   always_ff @(posedge clk) begin
      if (reset) p_state <= P_HUNT;
      else       p_state <= p_state_nxt;
   end

   // parser next-state: length-framed receive, then one word outstanding at a time
   always_comb begin
      p_state_nxt = p_state;
      case (p_state)
         P_HUNT:  if (rx_valid && rx_byte == SYNC_BYTE) p_state_nxt = P_DATA;
         P_DATA:  if (rx_ferr || timeout_hit)           p_state_nxt = P_HUNT;
                  else if (rx_valid && byte_cnt == 5'd31) p_state_nxt = P_CSUM;
         P_CSUM:  if (rx_ferr || timeout_hit)           p_state_nxt = P_HUNT;
                  else if (rx_valid)                    p_state_nxt = csum_bad ? P_HUNT : P_WLOAD;
         P_WLOAD: p_state_nxt = P_WSTB;
         P_WSTB:  if (!i_wb_stall) begin
                     if (i_wb_ack) p_state_nxt = last_row ? P_WDONE : P_WNEXT;
                     else          p_state_nxt = P_WACK;
                  end
         P_WACK:  if (i_wb_ack) p_state_nxt = last_row ? P_WDONE : P_WNEXT;
         P_WNEXT: p_state_nxt = P_WSTB;
         P_WDONE: p_state_nxt = P_HUNT;
         default: p_state_nxt = P_HUNT;
      endcase
   end

   // parser datapath: byte count, running checksum, idle timer, row pointer
   always_ff @(posedge clk) begin
      if (reset) begin
         byte_cnt <= 5'd0;
         csum_acc <= 8'd0;
         to_cnt   <= '0;
         row      <= 3'd0;
      end else begin
         if (p_state == P_HUNT) begin
            byte_cnt <= 5'd0;
            csum_acc <= 8'd0;
            row      <= 3'd0;
         end else if (p_state == P_DATA && rx_valid) begin
            byte_cnt <= byte_cnt + 5'd1;
            csum_acc <= csum_acc ^ rx_byte;
         end
         if (p_state_nxt == P_WNEXT) row <= row + 3'd1;
         if (in_frame && !rx_valid) to_cnt <= to_cnt + 1'b1;
         else                       to_cnt <= '0;
      end
   end

   // frame buffer: byte n lands in row n/4, first byte of a row in the low lane
   always_ff @(posedge clk) begin
      if (!reset && p_state == P_DATA && rx_valid)
         frame_buf[byte_cnt[4:2]][{byte_cnt[1:0], 3'b000} +: 8] <= rx_byte;
   end

   // bus and status outputs decoded from state; all error sources merge into one pulse
   always_comb begin
      o_wb_cyc     = (p_state == P_WSTB) || (p_state == P_WACK) || (p_state == P_WNEXT);
      o_wb_stb     = (p_state == P_WSTB);
      o_wb_we      = 1'b1;
      o_wb_sel     = 4'hF;
      o_wb_addr    = row;
      o_wb_wdata   = (p_state == P_WSTB) ? frame_buf[row] : 32'd0;
      o_frame_done = (p_state == P_WDONE);
      o_err        = rx_ferr || timeout_hit || csum_bad || (in_write && rx_valid);
   end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Receives 8x8 RGB frames over the FTDI serial line and writes them into `matrix` through its 32-bit Wishbone slave port. It is a second Wishbone master beside `move_master`, sitting upstream of `matrix` and fed from `ftdi_txd`. It contains an 8N1 UART receiver, a framing and checksum parser, a one-frame buffer, and a pipelined-style Wishbone write sequencer.

## Interface
- `CLK_HZ`, 25_000_000, system clock frequency.
- `BAUD`, 115200, serial bit rate. `CLKS_PER_BIT = CLK_HZ/BAUD` (integer divide; 217 at defaults).
- `TIMEOUT_CYCLES`, 250_000, maximum idle cycles between bytes inside a frame (10 ms).
- `clk  in  1`  system clock; one clock domain only.
- `reset  in  1`  synchronous, active-high.
- `i_uart_rx  in  1`  async serial input, idle high.
- `o_wb_cyc  out  1`  bus cycle.
- `o_wb_stb  out  1`  strobe.
- `o_wb_we  out  1`  write enable; always 1 while `o_wb_stb` is high.
- `o_wb_addr  out  3`  row address, 0..7.
- `o_wb_sel  out  4`  byte select; always 4'hF.
- `o_wb_wdata  out  32`  row word.
- `i_wb_ack  in  1`  slave ack.
- `i_wb_stall  in  1`  slave stall.
- `i_wb_rdata  in  32`  ignored.
- `o_frame_done  out  1`  one-cycle pulse when a frame has been fully written.
- `o_err  out  1`  one-cycle pulse on any receive or protocol error.

## Operation
- **UART RX**
  - `i_uart_rx` passes through a 2-flop synchronizer.
  - A falling edge in the idle state starts a byte. Sample at `CLKS_PER_BIT/2`. If the line is high there, the start is false: return to idle with no error.
  - Then sample 8 data bits (LSB first) and the stop bit, each `CLKS_PER_BIT` apart.
  - Stop bit = 1: pulse internal `rx_valid` for one cycle with `rx_byte`.
  - Stop bit = 0: framing error. Pulse `o_err`, drop the byte, and force the parser to HUNT.
  - The receiver returns to idle right after the stop sample.
- **Frame format**
  - Sync byte 0xA5, then 32 data bytes, then a checksum byte.
  - Checksum = XOR of the 32 data bytes.
  - Framing is by length. 0xA5 inside the data is ordinary data.
- **Buffer mapping:** data byte n (0..31) goes to row `n>>2`, bits `[8*(n&3)+7 : 8*(n&3)]`. The first byte of each row lands in the low byte, matching the `matrix` layout `[.RGB.RGB]` per byte.
- **Parser states**
  - HUNT
    - On `rx_valid` with byte 0xA5, go to DATA with count = 0 and xor = 0.
    - Any other byte is ignored silently.
  - DATA
    - Each `rx_valid` stores the byte, XORs it into the checksum, and increments the count.
    - After byte 31, go to CSUM.
  - CSUM
    - On `rx_valid`, if the byte equals xor, go to WRITE.
    - Otherwise pulse `o_err` and go to HUNT.
  - WRITE
    - Burst rows 0..7 (see below).
    - After the 8th ack, pulse `o_frame_done` and go to HUNT.
  - Timeout: in DATA or CSUM, if `TIMEOUT_CYCLES` elapse with no `rx_valid`, pulse `o_err` and go to HUNT. The counter clears on every `rx_valid`.
  - In WRITE, `rx_valid` bytes are dropped and `o_err` pulses. The receiver keeps running.
- **Wishbone burst**
  - `o_wb_cyc` stays high for the whole 8-word burst. Only one word is outstanding at a time.
  - For each row r:
    - Raise `o_wb_stb` with addr = r and wdata = row r.
    - Hold stb, addr and wdata stable while `i_wb_stall` = 1.
    - Drop stb on the cycle after it is accepted (stb && !stall).
    - Wait for `i_wb_ack`.
    - Raise stb for row r+1 on the cycle after the ack.
  - An ack arriving in the same cycle as acceptance counts.
  - There is no ack timeout.
- **Simultaneous events:** a framing error and a timeout in the same cycle produce a single `o_err` pulse.

## Timing
- **Reset values:** `o_wb_cyc`, `o_wb_stb`, `o_frame_done`, `o_err` = 0; `o_wb_addr` = 0; `o_wb_sel` = 4'hF; `o_wb_we` = 1; `o_wb_wdata` = 0.
  - Parser goes to HUNT, RX to idle, and the timeout counter to 0.
  - Buffer contents are don't-care.
- **Reset mid-burst:** `o_wb_cyc` and `o_wb_stb` are low on the first edge after reset is sampled high. No `o_frame_done` is produced.
- **Burst start:** `o_wb_cyc` and `o_wb_stb` go high 2 cycles after the checksum `rx_valid` cycle (one cycle to enter WRITE, one to issue).
- **Burst length:** with no stall and ack one cycle after stb, the burst is 8 × 3 = 24 cycles.
- **Burst end:** `o_frame_done` pulses in the cycle after the 8th ack. `o_wb_cyc` is low in that same cycle.
- **Byte latency:** `rx_valid` follows the stop-bit sample by 1 cycle. That is about 9.5 × `CLKS_PER_BIT` + 3 cycles after the start edge on `i_uart_rx`, including the synchronizer.

## Test plan
Bench parameters: `CLK_HZ` = 1000, `BAUD` = 100 (10 clocks per bit), `TIMEOUT_CYCLES` = 500. The Wishbone slave model acks one cycle after acceptance.

- **Valid frame:** 0xA5, bytes 0x00..0x1F, checksum 0x00 → 8 writes, addr 0..7, row0 = 32'h03020100, row7 = 32'h1F1E1D1C, sel = 4'hF, then one `o_frame_done` pulse. No `o_err`.
- **Bad checksum:** the same frame with checksum 0x01 → `o_err` pulses once and `o_wb_cyc` never rises. A following valid frame is written correctly.
- **Framing error:** stop bit driven 0 on data byte 5 → `o_err` pulses and the parser returns to HUNT. The rest of the bytes do not trigger a write unless one is 0xA5 followed by a valid structure.
- **Timeout:** send 0xA5 plus 10 bytes, then idle 600 clocks → `o_err` pulses once, about 500 cycles after the last byte. No bus activity.
- **Stall:** the slave asserts stall for 3 cycles on row 2 → stb, addr and wdata stay constant through the stall. Exactly 8 acks. `o_frame_done` arrives 3 cycles later than the no-stall case.
- **Reset mid-burst:** assert reset while row 4's stb is high → cyc and stb are 0 on the next edge, no `o_frame_done`, and a new valid frame after reset writes all 8 rows.
